// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing helpers for the sequential divider
package div_pkg;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Iteration counter width; must hold N-1 and never collapse to zero bits.
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift in a dividend bit, trial-subtract the divisor
module div_step #(
    parameter int N = 3
) (
    input  logic [N:0]   p_in,
    input  logic         bit_in,
    input  logic [N-1:0] y,
    output logic [N:0]   p_out,
    output logic         qbit
);

    logic [N:0] t;

    // A set top bit of p_in would mean the shifted value already exceeds any N-bit divisor.
    always_comb begin
        t     = {p_in[N-1:0], bit_in};
        qbit  = p_in[N] | (t >= {1'b0, y});
        p_out = qbit ? (t - {1'b0, y}) : t;
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring unsigned divider, one quotient bit per clock (optional DIV_SEQ_DZ_EN)
module div_seq
    import div_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         dz
);

    localparam int CNT_W = cnt_w(N);

    state_t             state_q;
    logic [N-1:0]       d_q;
    logic [N-1:0]       y_q;
    logic [N:0]         p_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [N-1:0]       q_q;
    logic [N-1:0]       r_q;
    logic               dz_q;

    logic [N:0]         p_d;
    logic               qbit;
    logic [N-1:0]       d_d;

    div_step #(.N(N)) u_step (
        .p_in   (p_q),
        .bit_in (d_q[N-1]),
        .y      (y_q),
        .p_out  (p_d),
        .qbit   (qbit)
    );

    // The dividend register doubles as the quotient register as bits shift out.
    assign d_d = {d_q[N-2:0], qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            d_q     <= '0;
            y_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dz_q <= 1'b0;
`ifdef DIV_SEQ_DZ_EN
                        if (y == '0) begin
                            done_q <= 1'b1;
                            dz_q   <= 1'b1;
                            q_q    <= '1;
                            r_q    <= x;
                        end else
`endif
                        begin
                            d_q     <= x;
                            y_q     <= y;
                            p_q     <= '0;
                            cnt_q   <= CNT_W'(N - 1);
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    d_q   <= d_d;
                    p_q   <= p_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        q_q     <= d_d;
                        r_q     <= p_d[N-1:0];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq (N=3), honours DIV_SEQ_DZ_EN
module tb_div_seq;

    localparam int N = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;

    int n_checks;
    int n_fail;

    div_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle so a
    // following call lands in that done cycle (back-to-back).
    task automatic run_op(input string tag, input int xv, input int yv, input int exp_q,
                          input int exp_r, input int exp_lat, input int exp_dz);
        bit found;
        int lat;
        found = 1'b0;
        lat   = 0;
        start = 1'b1;
        x     = N'(xv);
        y     = N'(yv);
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                lat   = k;
            end else begin
                check({tag, "_busy"}, busy, 1);
            end
        end
        if (!found) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_busy_done"}, busy, 0);
            check({tag, "_q"}, q, exp_q);
            check({tag, "_r"}, r, exp_r);
            check({tag, "_dz"}, dz, exp_dz);
        end
    endtask

    initial begin
        bit found;
        int lat;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        x        = '0;
        y        = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dz", dz, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 7/2: busy for cycles 1-3, done in cycle 4
        run_op("t1", 7, 2, 3, 1, 4, 0);
        @(negedge clk);
        check("t1_done_low", done, 0);
        check("t1_q_hold", q, 3);
        check("t1_r_hold", r, 1);

        // exhaustive back-to-back; latency 4 proves no idle cycle between ops
        for (int xi = 1; xi <= 7; xi++) begin
            for (int yi = 1; yi <= 7; yi++) begin
                run_op($sformatf("ex_%0d_%0d", xi, yi), xi, yi, xi / yi, xi % yi, 4, 0);
            end
        end
        @(negedge clk);

        run_op("t3a", 5, 7, 0, 5, 4, 0);
        run_op("t3b", 0, 5, 0, 0, 4, 0);

`ifdef DIV_SEQ_DZ_EN
        run_op("t4_dz", 6, 0, 7, 6, 1, 1);
`else
        run_op("t4_dz", 6, 0, 7, 6, 4, 0);
`endif
        @(negedge clk);
        check("t4_dz_hold", dz, `ifdef DIV_SEQ_DZ_EN 1 `else 0 `endif);

        // start while busy must be ignored
        found = 1'b0;
        lat   = 0;
        start = 1'b1;
        x     = 3'd7;
        y     = 3'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        lat   = 1;
        start = 1'b1;
        x     = 3'd1;
        y     = 3'd1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 2; k <= 20 && !found; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check("t5_found", found, 1);
        check("t5_lat", lat, 4);
        check("t5_q", q, 2);
        check("t5_r", r, 1);
        check("t5_dz", dz, 0);
        @(negedge clk);
        check("t5_no_restart", busy, 0);

        // asynchronous reset in the middle of a division
        start = 1'b1;
        x     = 3'd7;
        y     = 3'd2;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_q", q, 0);
        check("t6_r", r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_idle", busy, 0);
        run_op("t6_new", 6, 3, 2, 0, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
